reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters SHALL be: data_width, default 16, result/value width; tag_width, default 3, ROB index and CDB tag width; entries, fixed at 2**tag_width (8).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; clears all state.
REQ-004 flush  in  1  synchronous squash of all in-flight entries; mispredict/exception recovery.
REQ-005 alloc_req  in  1  issue stage requests one entry this cycle.
REQ-006 alloc_dest  in  3  destination architectural register of the issuing instruction.
REQ-007 alloc_ld_reg  in  1  issuing instruction writes a register.
REQ-008 alloc_tag  out  tag_width  tail index; the tag the issue stage stamps into the reservation station as dest.
REQ-009 full  out  1  all entries busy.
REQ-010 empty  out  1  no entries busy.
REQ-011 CDB_in  in  CDB  broadcast bus from the CDB arbiter; fields valid, tag, data.
REQ-012 rd_tag_a, rd_tag_b  in  tag_width  operand lookup tags from the issue stage.
REQ-013 rd_ready_a, rd_ready_b  out  1  looked-up entry is busy and done.
REQ-014 rd_value_a, rd_value_b  out  data_width  stored value of the looked-up entry.
REQ-015 commit_valid  out  1  head entry retires this cycle.
REQ-016 commit_dest / commit_ld_reg / commit_value / commit_tag  out  3 / 1 / data_width / tag_width  retiring entry fields, for the register file and the register-status table.

Function
REQ-017 Each entry SHALL hold busy, done, ld_reg, dest[2:0] and value[data_width-1:0]; head, tail and count (tag_width+1 bits) SHALL be registered.
REQ-018 alloc_tag SHALL equal tail combinationally; full SHALL be count==entries; empty SHALL be count==0.
REQ-019 When alloc_req=1 and full=0, the edge SHALL write busy=1, done=0, dest and ld_reg into entry[tail] and advance tail by 1 modulo entries.
REQ-020 alloc_req while full SHALL be ignored, even when a commit occurs in the same cycle (no same-cycle alloc-on-free).
REQ-021 When CDB_in.valid=1 and entry[CDB_in.tag].busy=1, the edge SHALL set done=1 and value=CDB_in.data. A CDB hit on a non-busy entry, including the entry being allocated that cycle, SHALL be ignored.
REQ-022 commit_valid SHALL be combinational: entry[head].busy & entry[head].done. commit_* fields SHALL reflect entry[head].
REQ-023 When commit_valid=1, the edge SHALL clear entry[head].busy/done and advance head modulo entries. At most one commit SHALL occur per cycle. Commit latency from the CDB write SHALL be at least 1 cycle.
REQ-024 count SHALL be incremented by alloc, decremented by commit, and left unchanged when both occur in the same cycle.
REQ-025 rd_ready_x and rd_value_x SHALL be combinational reads of the entry state. They do not bypass a same-cycle CDB; the issue stage snoops the CDB for that case.
REQ-026 Head and tail SHALL wrap from entries-1 to 0 with no gap or special case.
REQ-027 flush=1 SHALL, at the edge, clear all busy/done bits, set head=tail=count=0, and suppress any same-cycle alloc, CDB write or commit side-effect. commit_valid SHALL still be driven combinationally during the flush cycle, and the consumer qualifies it with ~flush.

Reset
REQ-028 On reset: head=tail=count=0, all busy/done=0, value=0, dest=0, ld_reg=0.
REQ-029 After reset the outputs SHALL be: full=0, empty=1, alloc_tag=0, commit_valid=0, rd_ready_x=0.
REQ-030 Reset SHALL take priority over flush, alloc, CDB and commit, including mid-operation with partially filled entries.

Structure
REQ-031 CDB struct and lc3b_word SHALL come from lc3b_types. A rob_entry struct (busy, done, ld_reg, dest, value) SHALL be added to lc3b_types for reuse by the register-status and debug logic.
REQ-032 A single sub-module rob_ptr (modulo counter with increment enable and synchronous clear) SHALL be instantiated for head and for tail. Everything else is flat.

Verification
REQ-033 Directed scenario, fill and stall: reset, 8 allocs -> tags 0..7, full=1; 9th alloc -> tail stays 0, count stays 8.
REQ-034 Directed scenario, out-of-order completion with in-order commit: alloc tags 0,1,2; CDB tag2=0x0003, then tag0=0x0001 -> commit tag0 value 0x0001 next cycle; no commit of tag2 until tag1 has been written with 0x0002; then commits tag1 followed by tag2.
REQ-035 Directed scenario, wrap: steady alloc/complete/commit of 20 instructions -> tags cycle 0..7,0..; count never exceeds 8; commit order matches alloc order.
REQ-036 Directed scenario, simultaneous alloc and commit at count=5 -> count stays 5; tail and head both advance by 1.
REQ-037 Directed scenario, flush: flush with 4 busy entries plus a same-cycle alloc and CDB -> next cycle empty=1, alloc_tag=0, no commit.
REQ-038 Directed scenario, stale-tag lookup: CDB to a non-busy tag and the rd ports -> no state change; rd_ready=0 for that tag.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: machine word, CDB broadcast
// bundle and the reorder-buffer entry record.
package lc3b_types;

    localparam int word_width = 16;
    localparam int rob_tag_width = 3;

    typedef logic [word_width-1:0] lc3b_word;
    typedef logic [rob_tag_width-1:0] lc3b_rob_tag;
    typedef logic [2:0] lc3b_reg;

    typedef struct packed {
        logic        valid;
        lc3b_rob_tag tag;
        lc3b_word    data;
    } CDB;

    typedef struct packed {
        logic     busy;
        logic     done;
        logic     ld_reg;
        lc3b_reg  dest;
        lc3b_word value;
    } rob_entry;

endpackage

// File: rtl/rob_ptr.sv
// Modulo-2**width pointer for the reorder buffer head/tail.
// Ports: clk, reset (sync), clear (sync), inc (advance), ptr.
module rob_ptr #(
    parameter int width = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [width-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr <= '0;
        end else if (inc) begin
            // Natural binary wrap gives entries-1 -> 0.
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer: allocates at tail, captures
// CDB results by tag, commits the head entry once done.
// Ports: clk/reset/flush; alloc_* + alloc_tag/full/empty
// (issue); CDB_in (results); rd_tag/ready/value a,b (operand
// lookup); commit_* (retire to regfile / reg-status table).
module reorder_buffer
    import lc3b_types::*;
#(
    parameter int data_width = 16,
    parameter int tag_width  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,

    input  logic                  alloc_req,
    input  logic [2:0]            alloc_dest,
    input  logic                  alloc_ld_reg,
    output logic [tag_width-1:0]  alloc_tag,
    output logic                  full,
    output logic                  empty,

    input  CDB                    CDB_in,

    input  logic [tag_width-1:0]  rd_tag_a,
    input  logic [tag_width-1:0]  rd_tag_b,
    output logic                  rd_ready_a,
    output logic                  rd_ready_b,
    output logic [data_width-1:0] rd_value_a,
    output logic [data_width-1:0] rd_value_b,

    output logic                  commit_valid,
    output logic [2:0]            commit_dest,
    output logic                  commit_ld_reg,
    output logic [data_width-1:0] commit_value,
    output logic [tag_width-1:0]  commit_tag
);

    localparam int entries = 2 ** tag_width;
    localparam logic [tag_width:0] max_count =
        (tag_width+1)'(entries);

    rob_entry             entry_q [entries];
    logic [tag_width-1:0] head;
    logic [tag_width-1:0] tail;
    logic [tag_width:0]   count;

    logic do_alloc;
    logic do_commit;

    assign full  = (count == max_count);
    assign empty = (count == '0);
    assign alloc_tag = tail;

    // No alloc-on-free: full is sampled before this cycle's commit.
    assign do_alloc  = alloc_req & ~full & ~flush;

    assign commit_valid  = entry_q[head].busy &
                           entry_q[head].done;
    assign commit_dest   = entry_q[head].dest;
    assign commit_ld_reg = entry_q[head].ld_reg;
    assign commit_value  = entry_q[head].value;
    assign commit_tag    = head;

    assign do_commit = commit_valid & ~flush;

    // No CDB bypass; the issue stage snoops the bus itself.
    assign rd_ready_a = entry_q[rd_tag_a].busy &
                        entry_q[rd_tag_a].done;
    assign rd_ready_b = entry_q[rd_tag_b].busy &
                        entry_q[rd_tag_b].done;
    assign rd_value_a = entry_q[rd_tag_a].value;
    assign rd_value_b = entry_q[rd_tag_b].value;

    rob_ptr #(.width(tag_width)) u_head (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (do_commit),
        .ptr   (head)
    );

    rob_ptr #(.width(tag_width)) u_tail (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (do_alloc),
        .ptr   (tail)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else begin
            unique case ({do_alloc, do_commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < entries; i++) begin
            if (reset) begin
                entry_q[i] <= '0;
            end else if (flush) begin
                entry_q[i].busy <= 1'b0;
                entry_q[i].done <= 1'b0;
            end else begin
                // Hit only counts on an already-busy entry, so the
                // slot being allocated this cycle is never written.
                if (CDB_in.valid && entry_q[i].busy &&
                    CDB_in.tag == tag_width'(i)) begin
                    entry_q[i].done  <= 1'b1;
                    entry_q[i].value <= CDB_in.data;
                end
                if (do_commit && head == tag_width'(i)) begin
                    entry_q[i].busy <= 1'b0;
                    entry_q[i].done <= 1'b0;
                end
                if (do_alloc && tail == tag_width'(i)) begin
                    entry_q[i].busy   <= 1'b1;
                    entry_q[i].done   <= 1'b0;
                    entry_q[i].dest   <= alloc_dest;
                    entry_q[i].ld_reg <= alloc_ld_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
// Linear scenario sequence with hand-computed expectations.
module tb_reorder_buffer;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        alloc_req;
    logic [2:0]  alloc_dest;
    logic        alloc_ld_reg;
    logic [2:0]  alloc_tag;
    logic        full;
    logic        empty;
    CDB          cdb;
    logic [2:0]  rd_tag_a;
    logic [2:0]  rd_tag_b;
    logic        rd_ready_a;
    logic        rd_ready_b;
    logic [15:0] rd_value_a;
    logic [15:0] rd_value_b;
    logic        commit_valid;
    logic [2:0]  commit_dest;
    logic        commit_ld_reg;
    logic [15:0] commit_value;
    logic [2:0]  commit_tag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.data_width(16), .tag_width(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .alloc_req     (alloc_req),
        .alloc_dest    (alloc_dest),
        .alloc_ld_reg  (alloc_ld_reg),
        .alloc_tag     (alloc_tag),
        .full          (full),
        .empty         (empty),
        .CDB_in        (cdb),
        .rd_tag_a      (rd_tag_a),
        .rd_tag_b      (rd_tag_b),
        .rd_ready_a    (rd_ready_a),
        .rd_ready_b    (rd_ready_b),
        .rd_value_a    (rd_value_a),
        .rd_value_b    (rd_value_b),
        .commit_valid  (commit_valid),
        .commit_dest   (commit_dest),
        .commit_ld_reg (commit_ld_reg),
        .commit_value  (commit_value),
        .commit_tag    (commit_tag)
    );

    task automatic check(input string name,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h",
                   name, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 1'b0;
        cdb = '0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic alloc(input logic [2:0] d);
        alloc_req = 1'b1;
        alloc_dest = d;
        alloc_ld_reg = 1'b1;
        cyc();
        alloc_req = 1'b0;
    endtask

    task automatic bcast(input logic [2:0] t,
                         input logic [15:0] v);
        cdb.valid = 1'b1;
        cdb.tag = t;
        cdb.data = v;
    endtask

    int ncommit;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        alloc_req = 1'b0;
        alloc_dest = '0;
        alloc_ld_reg = 1'b0;
        cdb = '0;
        rd_tag_a = '0;
        rd_tag_b = '0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_tag", 32'(alloc_tag), 0);
        check("rst_commit", 32'(commit_valid), 0);
        check("rst_rdy_a", 32'(rd_ready_a), 0);

        // Fill and stall
        for (int i = 0; i < 8; i++) begin
            alloc_req = 1'b1;
            alloc_dest = 3'(i);
            alloc_ld_reg = 1'b1;
            #1;
            check("fill_tag", 32'(alloc_tag), i);
            cyc();
        end
        alloc_req = 1'b0;
        check("fill_full", 32'(full), 1);
        check("fill_empty", 32'(empty), 0);
        alloc(3'd7);
        check("stall_tag", 32'(alloc_tag), 0);
        check("stall_full", 32'(full), 1);
        check("stall_commit", 32'(commit_valid), 0);

        // Reset wins over everything mid-operation
        reset = 1'b1;
        alloc_req = 1'b1;
        bcast(3'd0, 16'h1234);
        cyc();
        do_reset();
        check("midrst_empty", 32'(empty), 1);
        check("midrst_tag", 32'(alloc_tag), 0);
        rd_tag_a = 3'd0;
        #1;
        check("midrst_rdy", 32'(rd_ready_a), 0);

        // Out-of-order completion, in-order commit
        alloc(3'd5);
        alloc(3'd6);
        alloc(3'd7);
        bcast(3'd2, 16'h0003);
        cyc();
        idle();
        #1;
        check("ooo_nocommit2", 32'(commit_valid), 0);
        rd_tag_b = 3'd2;
        #1;
        check("ooo_rdy2", 32'(rd_ready_b), 1);
        check("ooo_val2", 32'(rd_value_b), 16'h0003);
        bcast(3'd0, 16'h0001);
        rd_tag_a = 3'd0;
        #1;
        check("ooo_nobypass", 32'(rd_ready_a), 0);
        cyc();
        idle();
        #1;
        check("ooo_c0_valid", 32'(commit_valid), 1);
        check("ooo_c0_tag", 32'(commit_tag), 0);
        check("ooo_c0_val", 32'(commit_value), 16'h0001);
        check("ooo_c0_dest", 32'(commit_dest), 5);
        check("ooo_c0_ld", 32'(commit_ld_reg), 1);
        cyc();
        check("ooo_wait1", 32'(commit_valid), 0);
        cyc();
        check("ooo_wait1b", 32'(commit_valid), 0);
        bcast(3'd1, 16'h0002);
        cyc();
        idle();
        #1;
        check("ooo_c1_valid", 32'(commit_valid), 1);
        check("ooo_c1_tag", 32'(commit_tag), 1);
        check("ooo_c1_val", 32'(commit_value), 16'h0002);
        cyc();
        check("ooo_c2_valid", 32'(commit_valid), 1);
        check("ooo_c2_tag", 32'(commit_tag), 2);
        check("ooo_c2_val", 32'(commit_value), 16'h0003);
        check("ooo_c2_dest", 32'(commit_dest), 7);
        cyc();
        check("ooo_drained", 32'(empty), 1);

        // Stale-tag CDB write and lookup
        bcast(3'd5, 16'hdead);
        cyc();
        idle();
        rd_tag_a = 3'd5;
        #1;
        check("stale_rdy", 32'(rd_ready_a), 0);
        check("stale_empty", 32'(empty), 1);
        check("stale_commit", 32'(commit_valid), 0);
        check("stale_tag", 32'(alloc_tag), 3);

        // Wrap: 20 instructions streaming through
        do_reset();
        ncommit = 0;
        for (int c = 0; c < 23; c++) begin
            idle();
            if (c < 20) begin
                alloc_req = 1'b1;
                alloc_dest = 3'(c);
                alloc_ld_reg = 1'b1;
            end
            if (c >= 1 && c <= 20)
                bcast(3'(c - 1), 16'(100 + c - 1));
            #1;
            if (c < 20)
                check("wrap_tag", 32'(alloc_tag), c % 8);
            check("wrap_notfull", 32'(full), 0);
            if (commit_valid) begin
                check("wrap_ctag", 32'(commit_tag),
                      ncommit % 8);
                check("wrap_cval", 32'(commit_value),
                      100 + ncommit);
                ncommit++;
            end
            cyc();
        end
        idle();
        check("wrap_ncommit", ncommit, 20);
        check("wrap_empty", 32'(empty), 1);

        // Simultaneous alloc and commit at count=5
        do_reset();
        for (int i = 0; i < 5; i++) alloc(3'(i));
        bcast(3'd0, 16'h0aaa);
        cyc();
        idle();
        alloc_req = 1'b1;
        alloc_dest = 3'd5;
        #1;
        check("sim_cvalid", 32'(commit_valid), 1);
        check("sim_atag", 32'(alloc_tag), 5);
        cyc();
        idle();
        #1;
        check("sim_tail", 32'(alloc_tag), 6);
        check("sim_head_nc", 32'(commit_valid), 0);
        alloc(3'd6);
        alloc(3'd7);
        check("sim_cnt7", 32'(full), 0);
        alloc(3'd0);
        check("sim_cnt8", 32'(full), 1);
        bcast(3'd1, 16'h0011);
        cyc();
        idle();
        #1;
        check("sim_head_valid", 32'(commit_valid), 1);
        check("sim_head_tag", 32'(commit_tag), 1);

        // Flush with 4 busy entries plus same-cycle alloc/CDB
        do_reset();
        for (int i = 0; i < 4; i++) alloc(3'(i));
        bcast(3'd0, 16'h0055);
        cyc();
        idle();
        flush = 1'b1;
        alloc_req = 1'b1;
        bcast(3'd1, 16'h0077);
        #1;
        check("fl_cvalid_during", 32'(commit_valid), 1);
        cyc();
        idle();
        rd_tag_a = 3'd0;
        rd_tag_b = 3'd1;
        #1;
        check("fl_empty", 32'(empty), 1);
        check("fl_tag", 32'(alloc_tag), 0);
        check("fl_commit", 32'(commit_valid), 0);
        check("fl_rdy_a", 32'(rd_ready_a), 0);
        check("fl_rdy_b", 32'(rd_ready_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
